lcd_bus_arbiter: RTL and testbench

Shares the single character-LCD write bus (RS/RW/EN/DATA) between two requesters, e.g. the key-status display path and the IR-command display path. Grants one requester at a time and latches its byte. Sequences the HD44780 write cycle (setup, enable pulse, hold, execution wait), then acknowledges the requester. Sits between the display formatters and the LCD pins, clocked from CLOCK_50.

---
 rtl/lcd_bus_arbiter_if.sv | 37 +++
 rtl/lcd_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_arbiter_if.sv
// ============================================================================
// Module   : lcd_bus_arbiter_if
// Brief    : Requester handshake and LCD pin bundle for lcd_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_bus_arbiter_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       ack1;
  logic       busy;
  logic       grant;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic [7:0] LCD_DATA;

  // Requester / pin-observer side
  modport master (
    output req0, rs0, data0, req1, rs1, data1,
    input  ack0, ack1, busy, grant, LCD_RS, LCD_RW, LCD_EN, LCD_DATA
  );

  // Arbiter side
  modport slave (
    input  req0, rs0, data0, req1, rs1, data1,
    output ack0, ack1, busy, grant, LCD_RS, LCD_RW, LCD_EN, LCD_DATA
  );
endinterface

`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
// ============================================================================
// Module   : lcd_bus_arbiter
// Brief    : Two-requester arbiter and HD44780 write-cycle sequencer.
//            Define LCD_ARB_RR_EN for round-robin arbitration (default: fixed
//            priority, requester 0 wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_arbiter #(
  parameter int T_SETUP     = 2,
  parameter int T_PW        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 17
) (
  input  wire logic          CLOCK_50,
  input  wire logic          RESET_N,
  lcd_bus_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_setup     = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] c_pw        = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] c_hold      = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] c_exec      = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] c_exec_long = CNT_W'(T_EXEC_LONG - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic             r_en,    w_en_nxt;
  logic             r_rs,    w_rs_nxt;
  logic [7:0]       r_data,  w_data_nxt;
  logic             r_grant, w_grant_nxt;
  logic             r_ack0,  w_ack0_nxt;
  logic             r_ack1,  w_ack1_nxt;
  logic             w_any_req;
  logic             w_winner;
  logic             w_timer_zero;
  logic             w_long_exec;

`ifdef LCD_ARB_RR_EN
  // Pointer names the requester that wins the next simultaneous request
  logic             r_ptr,   w_ptr_nxt;

  always_comb begin
    if (bus.req0 && bus.req1) begin
      w_winner = r_ptr;
    end else begin
      w_winner = bus.req1;
    end
  end
`else
  always_comb begin
    w_winner = ~bus.req0;
  end
`endif

  assign w_any_req    = bus.req0 | bus.req1;
  assign w_timer_zero = (r_timer == '0);
  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait
  assign w_long_exec  = ~r_rs && (r_data[7:2] == 6'b000000);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_en_nxt    = r_en;
    w_rs_nxt    = r_rs;
    w_data_nxt  = r_data;
    w_grant_nxt = r_grant;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
`ifdef LCD_ARB_RR_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant_nxt = w_winner;
          w_rs_nxt    = w_winner ? bus.rs1   : bus.rs0;
          w_data_nxt  = w_winner ? bus.data1 : bus.data0;
          w_timer_nxt = c_setup;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_timer_zero) begin
          w_en_nxt    = 1'b1;
          w_timer_nxt = c_pw;
          w_state_nxt = S_PULSE;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_PULSE: begin
        if (w_timer_zero) begin
          w_en_nxt    = 1'b0;
          w_timer_nxt = c_hold;
          w_state_nxt = S_HOLD;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_HOLD: begin
        if (w_timer_zero) begin
          w_timer_nxt = w_long_exec ? c_exec_long : c_exec;
          w_state_nxt = S_EXEC;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_EXEC: begin
        if (w_timer_zero) begin
          w_state_nxt = S_ACK;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_ACK: begin
        w_ack0_nxt  = ~r_grant;
        w_ack1_nxt  = r_grant;
`ifdef LCD_ARB_RR_EN
        w_ptr_nxt   = ~r_grant;
`endif
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_en_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_grant <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
`ifdef LCD_ARB_RR_EN
      r_ptr   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_en    <= w_en_nxt;
      r_rs    <= w_rs_nxt;
      r_data  <= w_data_nxt;
      r_grant <= w_grant_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
`ifdef LCD_ARB_RR_EN
      r_ptr   <= w_ptr_nxt;
`endif
    end
  end

  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.grant    = r_grant;
  assign bus.LCD_RS   = r_rs;
  assign bus.LCD_RW   = 1'b0;
  assign bus.LCD_EN   = r_en;
  assign bus.LCD_DATA = r_data;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
// ============================================================================
// Module   : tb_lcd_bus_arbiter
// Brief    : Directed self-checking bench for lcd_bus_arbiter (short timings).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_bus_arbiter;

  localparam int c_lat      = 13;
  localparam int c_lat_long = 28;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  lcd_bus_arbiter_if bus ();

  lcd_bus_arbiter #(
    .T_SETUP     (2),
    .T_PW        (3),
    .T_HOLD      (2),
    .T_EXEC      (5),
    .T_EXEC_LONG (20),
    .CNT_W       (17)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called right after driving a request at a negedge; sample k is the
  // negedge following the k-th posedge (k=0 is the granting edge).
  task automatic run_txn(input int budget, input logic [7:0] exp_data,
                         input int chg_k, input logic [7:0] chg_val,
                         input int drop_k,
                         output int ack_k, output int ack_who, output int g0,
                         output int en_first, output int en_len, output int data_bad,
                         output int busy_at_ack);
    ack_k = -1; ack_who = -1; g0 = -1; en_first = -1; en_len = 0;
    data_bad = 0; busy_at_ack = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (k == 0) g0 = int'(bus.grant);
      if (bus.LCD_EN) begin
        if (en_first < 0) en_first = k;
        en_len++;
      end
      if (bus.LCD_DATA !== exp_data) data_bad++;
      if (k == chg_k) bus.data0 = chg_val;
      if (k == drop_k) bus.req0 = 1'b0;
      if (bus.ack0 || bus.ack1) begin
        ack_k = k;
        ack_who = bus.ack1 ? 1 : 0;
        busy_at_ack = int'(bus.busy);
        break;
      end
    end
  endtask

  int ack_k, ack_who, g0, en_first, en_len, data_bad, busy_at_ack;
  int exp_g;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.rs0 = 1'b0; bus.data0 = 8'h00;
    bus.req1 = 1'b0; bus.rs1 = 1'b0; bus.data1 = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_en",   32'(bus.LCD_EN),   0);
    check("rst_rs",   32'(bus.LCD_RS),   0);
    check("rst_rw",   32'(bus.LCD_RW),   0);
    check("rst_data", 32'(bus.LCD_DATA), 0);
    check("rst_busy", 32'(bus.busy),     0);
    check("rst_grant",32'(bus.grant),    0);
    check("rst_ack",  32'({bus.ack0, bus.ack1}), 0);

    // Single data write from requester 0
    bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h41;
    run_txn(60, 8'h41, -1, 8'h00, -1, ack_k, ack_who, g0, en_first, en_len, data_bad, busy_at_ack);
    bus.req0 = 1'b0;
    check("t1_grant",    32'(g0),       0);
    check("t1_rs",       32'(bus.LCD_RS), 1);
    check("t1_data",     32'(data_bad), 0);
    check("t1_en_first", 32'(en_first), 2);
    check("t1_en_len",   32'(en_len),   3);
    check("t1_ack_k",    32'(ack_k),    c_lat);
    check("t1_ack_who",  32'(ack_who),  0);
    check("t1_busy_ack", 32'(busy_at_ack), 0);
    @(negedge clk);
    check("t1_ack_once", 32'(bus.ack0), 0);
    check("t1_idle",     32'(bus.busy), 0);

    // Clear command takes the long execution wait
    bus.req1 = 1'b1; bus.rs1 = 1'b0; bus.data1 = 8'h01;
    run_txn(60, 8'h01, -1, 8'h00, -1, ack_k, ack_who, g0, en_first, en_len, data_bad, busy_at_ack);
    bus.req1 = 1'b0;
    check("t2_grant",   32'(g0),      1);
    check("t2_ack_k",   32'(ack_k),   c_lat_long);
    check("t2_ack_who", 32'(ack_who), 1);
    check("t2_rs",      32'(bus.LCD_RS), 0);
    @(negedge clk);

    // Set-DDRAM command uses the normal wait
    bus.req1 = 1'b1; bus.rs1 = 1'b0; bus.data1 = 8'h80;
    run_txn(60, 8'h80, -1, 8'h00, -1, ack_k, ack_who, g0, en_first, en_len, data_bad, busy_at_ack);
    bus.req1 = 1'b0;
    check("t3_ack_k",   32'(ack_k),   c_lat);
    check("t3_ack_who", 32'(ack_who), 1);
    check("t3_data",    32'(data_bad), 0);
    @(negedge clk);

    // Both requesters held continuously for four writes
    bus.rs0 = 1'b1; bus.data0 = 8'h30;
    bus.rs1 = 1'b1; bus.data1 = 8'h31;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef LCD_ARB_RR_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      run_txn(60, (exp_g == 1) ? 8'h31 : 8'h30, -1, 8'h00, -1,
              ack_k, ack_who, g0, en_first, en_len, data_bad, busy_at_ack);
      check($sformatf("t4_grant%0d", i),   32'(g0),      32'(exp_g));
      check($sformatf("t4_ack_who%0d", i), 32'(ack_who), 32'(exp_g));
      check($sformatf("t4_ack_k%0d", i),   32'(ack_k),   c_lat);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    check("t4_idle", 32'(bus.busy), 0);

    // Requester data changes during PULSE must not reach the pins
    bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h41;
    run_txn(60, 8'h41, 3, 8'h55, -1, ack_k, ack_who, g0, en_first, en_len, data_bad, busy_at_ack);
    bus.req0 = 1'b0;
    check("t5_data_stable", 32'(data_bad), 0);
    check("t5_ack_k",       32'(ack_k),    c_lat);
    @(negedge clk);

    // Reset while EN is high, then restart with req still held
    bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h66;
    repeat (3) @(negedge clk);
    check("t6_en_before", 32'(bus.LCD_EN), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_en",   32'(bus.LCD_EN),   0);
    check("t6_busy", 32'(bus.busy),     0);
    check("t6_data", 32'(bus.LCD_DATA), 0);
    check("t6_ack",  32'({bus.ack0, bus.ack1}), 0);
    rst_n = 1'b1;
    run_txn(60, 8'h66, -1, 8'h00, -1, ack_k, ack_who, g0, en_first, en_len, data_bad, busy_at_ack);
    bus.req0 = 1'b0;
    check("t6_restart_en",  32'(en_len), 3);
    check("t6_restart_ack", 32'(ack_k),  c_lat);
    @(negedge clk);

    // Dropping req during EXEC still completes with a single ack
    bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h42;
    run_txn(60, 8'h42, -1, 8'h00, 9, ack_k, ack_who, g0, en_first, en_len, data_bad, busy_at_ack);
    check("t7_ack_k",   32'(ack_k),   c_lat);
    check("t7_ack_who", 32'(ack_who), 0);
    data_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || bus.ack0) data_bad++;
    end
    check("t7_no_regrant", 32'(data_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
